// File: rtl/recip_arbiter.sv
// Round-robin arbiter sharing one combinational reciprocal unit between two requesters; grant to response in 2 edges, 3 cycles minimum per op.
// One transaction in flight; RESP holds the result until resp_ready, and no requester is accepted until it drains.
module recip_arbiter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0_valid,
   input  logic [W-1:0] req0_data,
   input  logic         req0_abs,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [W-1:0] req1_data,
   input  logic         req1_abs,
   output logic         req1_ready,
   output logic [W-1:0] o_recip_data,
   output logic         o_recip_abs,
   input  logic [W-1:0] i_recip_data,
   input  logic         i_recip_sat,
   output logic         resp_valid,
   output logic         resp_id,
   output logic [W-1:0] resp_data,
   output logic         resp_sat,
   input  logic         resp_ready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [W-1:0] data;
      logic         abs;
      logic         id;
   } op_t;

   state_t state, state_nxt;
   op_t    op_q, op_nxt;
   logic   ptr_q, ptr_nxt;
   logic   grant_vld;
   logic   grant_id;

   // Pointer only breaks ties; a lone requester wins regardless of it.
   always_comb begin
      grant_vld = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant_id = ptr_q;
      end else begin
         grant_id = req1_valid;
      end
   end

   always_comb begin
      state_nxt  = state;
      op_nxt     = op_q;
      ptr_nxt    = ptr_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            if (grant_vld && !reset) begin
               req0_ready = ~grant_id;
               req1_ready = grant_id;
               if (grant_id) begin
                  op_nxt.data = req1_data;
                  op_nxt.abs  = req1_abs;
                  op_nxt.id   = 1'b1;
               end else begin
                  op_nxt.data = req0_data;
                  op_nxt.abs  = req0_abs;
                  op_nxt.id   = 1'b0;
               end
               state_nxt = CALC;
            end
         end
         CALC: begin
            state_nxt = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               ptr_nxt   = ~op_q.id;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         op_q      <= '0;
         ptr_q     <= 1'b0;
         resp_data <= '0;
         resp_sat  <= 1'b0;
         resp_id   <= 1'b0;
      end else begin
         state <= state_nxt;
         op_q  <= op_nxt;
         ptr_q <= ptr_nxt;
         // Result is sampled once, the cycle the operand registers have been presented for.
         if (state == CALC) begin
            resp_data <= i_recip_data;
            resp_sat  <= i_recip_sat;
            resp_id   <= op_q.id;
         end
      end
   end

   assign o_recip_data = op_q.data;
   assign o_recip_abs  = op_q.abs;

endmodule

// File: tb/tb_recip_arbiter.sv
// Directed bench for recip_arbiter with a reciprocal-unit model and a response scoreboard.
module tb_recip_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [15:0] req0_data, req1_data;
   logic        req0_abs, req1_abs;
   logic        req0_ready, req1_ready;
   logic [15:0] o_recip_data;
   logic        o_recip_abs;
   logic [15:0] i_recip_data;
   logic        i_recip_sat;
   logic        resp_valid;
   logic        resp_id;
   logic [15:0] resp_data;
   logic        resp_sat;
   logic        resp_ready;

   typedef struct packed {
      logic        id;
      logic [15:0] data;
      logic        sat;
   } exp_t;

   exp_t exp_q[$];
   int   gnt_id_log[$];
   int   gnt_cyc_log[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   logic ptr_m = 1'b0;
   logic got;

   always #5 clk = ~clk;

   recip_arbiter #(.W(16)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_abs(req0_abs), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_abs(req1_abs), .req1_ready(req1_ready),
      .o_recip_data(o_recip_data), .o_recip_abs(o_recip_abs),
      .i_recip_data(i_recip_data), .i_recip_sat(i_recip_sat),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_sat(resp_sat),
      .resp_ready(resp_ready)
   );

   // Q6.10 reciprocal: 2^20 / |d|, sign kept unless abs mode, saturating at the rails.
   function automatic logic [16:0] rmodel(input logic [15:0] d, input logic a);
      logic [15:0] m;
      logic        neg;
      logic [31:0] q;
      neg = d[15] & ~a;
      m   = d[15] ? (16'd0 - d) : d;
      if (m == 16'd0) return {1'b1, 16'h7FFF};
      q = 32'h0010_0000 / {16'd0, m};
      if (q > 32'h0000_7FFF) return {1'b1, (neg ? 16'h8000 : 16'h7FFF)};
      return {1'b0, (neg ? (16'd0 - q[15:0]) : q[15:0])};
   endfunction

   assign {i_recip_sat, i_recip_data} = rmodel(o_recip_data, o_recip_abs);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic settle();
      #1;
   endtask

   // Observe grants and completions for the current cycle, then advance one clock.
   task automatic cycle();
      exp_t e;
      logic gid;
      if (!reset) begin
         if (req0_ready || req1_ready) begin
            gid = (req0_valid && req1_valid) ? ptr_m : req1_valid;
            chk("both_ready", 32'(req0_ready & req1_ready), 0);
            chk("grant_id", 32'(req1_ready), 32'(gid));
            chk("ready_without_valid", 32'((req0_ready & ~req0_valid) | (req1_ready & ~req1_valid)), 0);
            e.id = gid;
            {e.sat, e.data} = gid ? rmodel(req1_data, req1_abs) : rmodel(req0_data, req0_abs);
            exp_q.push_back(e);
            gnt_id_log.push_back(int'(gid));
            gnt_cyc_log.push_back(cyc);
         end
         if (resp_valid && resp_ready) begin
            chk("resp_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("sb_id", 32'(resp_id), 32'(e.id));
               chk("sb_data", 32'(resp_data), 32'(e.data));
               chk("sb_sat", 32'(resp_sat), 32'(e.sat));
               ptr_m = ~e.id;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      settle();
      chk("rst_rdy0", 32'(req0_ready), 0);
      chk("rst_rdy1", 32'(req1_ready), 0);
      cycle();
      reset = 1'b0;
      exp_q.delete();
      ptr_m = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         settle();
         cycle();
      end
      settle();
      chk("drain_empty", 32'(exp_q.size()), 0);
   endtask

   task automatic single_req(input logic id, input logic [15:0] d, input logic a,
                             input logic [15:0] ed, input logic es);
      resp_ready = 1'b1;
      if (id) begin
         req1_valid = 1'b1; req1_data = d; req1_abs = a;
      end else begin
         req0_valid = 1'b1; req0_data = d; req0_abs = a;
      end
      settle();
      chk("single_rdy", 32'(id ? req1_ready : req0_ready), 1);
      chk("single_other_rdy", 32'(id ? req0_ready : req1_ready), 0);
      cycle();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      settle();
      chk("single_calc_vld", 32'(resp_valid), 0);
      chk("single_op_data", 32'(o_recip_data), 32'(d));
      chk("single_op_abs", 32'(o_recip_abs), 32'(a));
      cycle();
      settle();
      chk("single_resp_vld", 32'(resp_valid), 1);
      chk("single_resp_id", 32'(resp_id), 32'(id));
      chk("single_resp_data", 32'(resp_data), 32'(ed));
      chk("single_resp_sat", 32'(resp_sat), 32'(es));
      cycle();
      settle();
      chk("single_idle_vld", 32'(resp_valid), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_data = '0; req1_data = '0;
      req0_abs = 1'b0; req1_abs = 1'b0;
      resp_ready = 1'b1;

      // Reset state
      do_reset();
      settle();
      chk("rst_resp_valid", 32'(resp_valid), 0);
      chk("rst_resp_id", 32'(resp_id), 0);
      chk("rst_resp_data", 32'(resp_data), 0);
      chk("rst_resp_sat", 32'(resp_sat), 0);
      chk("rst_op_data", 32'(o_recip_data), 0);
      chk("rst_op_abs", 32'(o_recip_abs), 0);

      // Single request: 2.0 -> 0.5
      single_req(1'b0, 16'h0800, 1'b0, 16'h0200, 1'b0);

      // Both held valid: alternating grants, 3 cycles apart, starting from requester 0
      do_reset();
      gnt_id_log.delete();
      gnt_cyc_log.delete();
      req0_valid = 1'b1; req0_data = 16'h0400;
      req1_valid = 1'b1; req1_data = 16'h0C00;
      repeat (12) begin
         settle();
         cycle();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      drain();
      chk("rr_count", 32'(gnt_id_log.size() >= 4), 1);
      if (gnt_id_log.size() >= 4) begin
         for (int i = 0; i < 4; i++) chk("rr_order", 32'(gnt_id_log[i]), 32'(i % 2));
         for (int i = 1; i < 4; i++) chk("rr_spacing", 32'(gnt_cyc_log[i] - gnt_cyc_log[i-1]), 3);
      end

      // Backpressure in RESP: 4.0 -> 0.25 held for 5 cycles
      resp_ready = 1'b0;
      req1_valid = 1'b1; req1_data = 16'h1000; req1_abs = 1'b0;
      settle();
      chk("bp_rdy1", 32'(req1_ready), 1);
      cycle();
      req1_valid = 1'b0;
      settle();
      cycle();
      req0_valid = 1'b1; req0_data = 16'h0400;
      req1_valid = 1'b1; req1_data = 16'h2000;
      repeat (5) begin
         settle();
         chk("bp_vld", 32'(resp_valid), 1);
         chk("bp_id", 32'(resp_id), 1);
         chk("bp_data", 32'(resp_data), 32'h0100);
         chk("bp_readys", 32'({req0_ready, req1_ready}), 0);
         cycle();
      end
      resp_ready = 1'b1;
      settle();
      cycle();
      settle();
      chk("bp_after_vld", 32'(resp_valid), 0);
      chk("bp_next_rdy0", 32'(req0_ready), 1);
      chk("bp_next_rdy1", 32'(req1_ready), 0);
      cycle();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      drain();

      // Saturation and sign handling
      single_req(1'b0, 16'h0000, 1'b0, 16'h7FFF, 1'b1);
      single_req(1'b1, 16'hF800, 1'b1, 16'h0200, 1'b0);
      single_req(1'b1, 16'hF800, 1'b0, 16'hFE00, 1'b0);

      // Reset mid-CALC with pointer favouring requester 1
      single_req(1'b0, 16'h0400, 1'b0, 16'h0400, 1'b0);
      req1_valid = 1'b1; req1_data = 16'h0800;
      settle();
      chk("rc_rdy1", 32'(req1_ready), 1);
      cycle();
      req0_valid = 1'b1; req0_data = 16'h0200;
      do_reset();
      settle();
      chk("rc_vld", 32'(resp_valid), 0);
      chk("rc_fav0", 32'(req0_ready), 1);
      chk("rc_not1", 32'(req1_ready), 0);
      cycle();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      drain();

      // Reset mid-RESP with pointer favouring requester 1
      single_req(1'b0, 16'h0400, 1'b0, 16'h0400, 1'b0);
      resp_ready = 1'b0;
      req1_valid = 1'b1; req1_data = 16'h0800;
      settle();
      cycle();
      req1_valid = 1'b0;
      settle();
      cycle();
      settle();
      chk("rr_resp_vld", 32'(resp_valid), 1);
      req0_valid = 1'b1; req0_data = 16'h0200;
      req1_valid = 1'b1;
      do_reset();
      settle();
      chk("rr_vld", 32'(resp_valid), 0);
      chk("rr_fav0", 32'(req0_ready), 1);
      resp_ready = 1'b1;
      cycle();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      drain();

      // Requester 1 churns while requester 0 is in flight
      req0_valid = 1'b1; req0_data = 16'h0200; req0_abs = 1'b0;
      settle();
      chk("ch_rdy0", 32'(req0_ready), 1);
      cycle();
      req0_valid = 1'b0;
      req1_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         req1_data = 16'($urandom_range(32'h0100, 32'h7FFF));
         req1_abs  = 1'($urandom_range(0, 1));
         settle();
         if (resp_valid) begin
            chk("ch_r0_id", 32'(resp_id), 0);
            chk("ch_r0_data", 32'(resp_data), 32'h0800);
         end
         got = req1_ready;
         cycle();
      end
      chk("ch_granted", 32'(got), 1);
      req1_valid = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
